// File: rtl/store_buffer.sv
// Store buffer: queues core stores in a small circular FIFO and drains them one per
// cycle to a single-ported data memory, giving loads priority unless they hit a buffered word.
module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [2:0]            st_mode,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_mode,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_stall,
    output logic                  empty,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [2:0]            mem_mode,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [2:0]            mode_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic [DEPTH-1:0] match;
    logic             hazard;
    logic             push;
    logic             load_port;
    logic             pop;

    // An entry is occupied when its distance from head (mod DEPTH) is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PW-1:0] offs;
            logic          occupied;
            assign offs     = PW'(gi) - head_q;
            assign occupied = ({1'b0, offs} < count_q);
            assign match[gi] = occupied &&
                               (addr_q[gi][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);
        end
    endgenerate

    assign hazard    = ld_valid && (|match);
    assign ld_stall  = hazard;
    assign st_ready  = (count_q < (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = st_valid && st_ready;
    assign load_port = ld_valid && !hazard;
    // Writes are suppressed while reset is held so discarded stores never reach memory.
    assign pop       = !rst && !load_port && (count_q != '0);

    assign mem_we   = pop;
    assign mem_a    = pop ? addr_q[head_q] : ld_addr;
    assign mem_wd   = data_q[head_q];
    assign mem_mode = mode_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            mode_q[tail_q] <= st_mode;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign ld_byte = mem_rd[{ld_addr[1:0], 3'b000} +: 8];
    assign ld_half = mem_rd[{ld_addr[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = mem_rd;
        case (ld_mode)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_rd;
        endcase
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model plus a behavioural data memory,
// directed corner sequences, a load-extension vector table and a randomized phase.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_mode;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_mode;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        empty;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_mode(st_mode),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode),
        .ld_data(ld_data), .ld_stall(ld_stall), .empty(empty),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_mode(mem_mode),
        .mem_rd(mem_rd)
    );

    // Byte-lane merge used by both the DUT-side memory and the reference memory.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [2:0] m);
        logic [31:0] r;
        r = old;
        case (m)
            3'd0:    r[8*int'(a[1:0]) +: 8] = d[7:0];
            3'd1:    r[16*int'(a[1]) +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] m);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a[1:0])) & 32'h0000_00FF;
        h = (w >> (16 * a[1])) & 32'h0000_FFFF;
        case (m)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // DUT-facing data memory: combinational read, write on the clock edge.
    logic [31:0] dmem [256];
    bit          mem_init_done = 1'b0;
    assign mem_rd = dmem[mem_a[9:2]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            dmem[mem_a[9:2]] <= merge(dmem[mem_a[9:2]], mem_a, mem_wd, mem_mode);
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  mode;
    } st_t;

    st_t         mq[$];
    logic [31:0] ref_mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance the model for the coming edge.
    task automatic model_cycle();
        int sz;
        bit hz;
        bit lp;
        bit we;
        sz = mq.size();
        hz = 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
        hz = hz && ld_valid;
        lp = ld_valid && !hz;
        we = !rst && !lp && (sz > 0);
        chk("st_ready", 32'(st_ready), 32'(sz < DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("ld_stall", 32'(ld_stall), 32'(hz));
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_a", mem_a, we ? mq[0].addr : ld_addr);
        if (we) begin
            chk("mem_wd", mem_wd, mq[0].data);
            chk("mem_mode", 32'(mem_mode), 32'(mq[0].mode));
        end
        if (lp) chk("ld_data", ld_data, ref_load(ref_mem[ld_addr[9:2]], ld_addr, ld_mode));
        if (rst) begin
            mq.delete();
        end else begin
            if (we) begin
                ref_mem[mq[0].addr[9:2]] = merge(ref_mem[mq[0].addr[9:2]], mq[0].addr,
                                                 mq[0].data, mq[0].mode);
                void'(mq.pop_front());
            end
            if (st_valid && sz < DEPTH) mq.push_back('{st_addr, st_data, st_mode});
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [2:0] sm, input bit lv, input logic [31:0] la,
                         input logic [2:0] lm);
        st_valid = sv; st_addr = sa; st_data = sd; st_mode = sm;
        ld_valid = lv; ld_addr = la; ld_mode = lm;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 32'h0, 32'h0, 3'd2, 0, 32'h0001_0000, 3'd2);
            step();
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[12];

    initial begin
        int accepted;
        int k;
        tv[0]  = '{32'h0001_0103, 3'd0, 32'hFFFF_FF80};
        tv[1]  = '{32'h0001_0101, 3'd4, 32'h0000_007F};
        tv[2]  = '{32'h0001_0102, 3'd1, 32'hFFFF_80FF};
        tv[3]  = '{32'h0001_0100, 3'd5, 32'h0000_7F01};
        tv[4]  = '{32'h0001_0100, 3'd2, 32'h80FF_7F01};
        tv[5]  = '{32'h0001_0102, 3'd0, 32'hFFFF_FFFF};
        tv[6]  = '{32'h0001_0103, 3'd4, 32'h0000_0080};
        tv[7]  = '{32'h0001_0100, 3'd1, 32'h0000_7F01};
        tv[8]  = '{32'h0001_0102, 3'd5, 32'h0000_80FF};
        tv[9]  = '{32'h0001_0101, 3'd0, 32'h0000_007F};
        tv[10] = '{32'h0001_0100, 3'd3, 32'h80FF_7F01};
        tv[11] = '{32'h0001_0100, 3'd7, 32'h80FF_7F01};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 3'd2, 0, 32'h0001_0000, 3'd2);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_st_ready", 32'(st_ready), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        step();

        // Fill: each word drains on the edge after it is accepted.
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, 32'h0001_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'd2,
                  0, 32'h0001_0000, 3'd2);
            if (i > 0) begin
                chk("fill_we", 32'(mem_we), 32'd1);
                chk("fill_addr", mem_a, 32'h0001_0000 + 32'(4 * (i - 1)));
            end
            step();
        end
        drive(0, 32'h0, 32'h0, 3'd2, 0, 32'h0001_0000, 3'd2);
        chk("fill_empty", 32'(empty), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0000 + 32'(4 * i), 3'd2);
            chk("fill_readback", ld_data, 32'hA000_0000 + 32'(i));
            step();
        end

        // Full: a non-hazard load holds the port so nothing drains.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h0001_0010 + 32'(4 * i), 32'hB000_0000 + 32'(i), 3'd2,
                  1, 32'h0001_0200, 3'd2);
            chk("full_no_we", 32'(mem_we), 32'd0);
            chk("full_ready", 32'(st_ready), 32'(i < 4));
            step();
        end
        drive(1, 32'h0001_0020, 32'hB000_0004, 3'd2, 0, 32'h0001_0200, 3'd2);
        chk("full_still_blocked", 32'(st_ready), 32'd0);
        chk("full_drain_resumes", 32'(mem_we), 32'd1);
        step();
        drive(1, 32'h0001_0020, 32'hB000_0004, 3'd2, 0, 32'h0001_0200, 3'd2);
        chk("full_fifth_ready", 32'(st_ready), 32'd1);
        step();
        idle(5);

        // Hazard: the load stalls exactly one cycle while the matching word drains.
        drive(1, 32'h0001_0004, 32'hDEAD_BEEF, 3'd2, 0, 32'h0001_0000, 3'd2);
        step();
        drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0004, 3'd2);
        chk("haz_stall", 32'(ld_stall), 32'd1);
        chk("haz_we", 32'(mem_we), 32'd1);
        step();
        drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0004, 3'd2);
        chk("haz_released", 32'(ld_stall), 32'd0);
        chk("haz_data", ld_data, 32'hDEAD_BEEF);
        step();

        // Extension table.
        drive(1, 32'h0001_0100, 32'h80FF_7F01, 3'd2, 0, 32'h0001_0000, 3'd2);
        step();
        idle(1);
        foreach (tv[i]) begin
            drive(0, 32'h0, 32'h0, 3'd2, 1, tv[i].addr, tv[i].mode);
            chk($sformatf("ext_vec%0d", i), ld_data, tv[i].exp);
            step();
        end

        // Wrap: ten stores with alternating unrelated loads.
        accepted = 0;
        k = 0;
        while (accepted < 10 && k < 100) begin
            drive(1, 32'h0001_0300 + 32'(4 * accepted), 32'hC000_0000 + 32'(accepted), 3'd2,
                  k[0], 32'h0001_0000, 3'd2);
            if (mq.size() < DEPTH) accepted++;
            step();
            k++;
        end
        chk("wrap_all_accepted", 32'(accepted), 32'd10);
        idle(6);
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0300 + 32'(4 * i), 3'd2);
            chk("wrap_order", ld_data, 32'hC000_0000 + 32'(i));
            step();
        end

        // Reset with three stores pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0001_0380 + 32'(4 * i), 32'hE000_0000 + 32'(i), 3'd2,
                  1, 32'h0001_0000, 3'd2);
            step();
        end
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 3'd2, 0, 32'h0001_0000, 3'd2);
        step();
        rst = 1'b0;
        drive(0, 32'h0, 32'h0, 3'd2, 0, 32'h0001_0000, 3'd2);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0380 + 32'(4 * i), 3'd2);
            chk("rst_discarded", ld_data, 32'h0);
            step();
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic [2:0]  sm;
            logic [2:0]  lm;
            logic [31:0] sa;
            logic [31:0] la;
            sm = 3'($urandom_range(0, 2));
            sa = 32'h0001_0000 + 32'($urandom_range(0, 15) << 2);
            if (sm == 3'd0) sa = sa + 32'($urandom_range(0, 3));
            if (sm == 3'd1) sa = sa + 32'($urandom_range(0, 1) * 2);
            case ($urandom_range(0, 5))
                0: lm = 3'd0;
                1: lm = 3'd1;
                2: lm = 3'd2;
                3: lm = 3'd4;
                4: lm = 3'd5;
                default: lm = 3'd3;
            endcase
            la = 32'h0001_0000 + 32'($urandom_range(0, 63));
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, sa, $urandom, sm,
                  $urandom_range(0, 2) == 0, la, lm);
            step();
        end
        rst = 1'b0;
        idle(6);
        for (int i = 0; i < 16; i++) begin
            drive(0, 32'h0, 32'h0, 3'd2, 1, 32'h0001_0000 + 32'(4 * i), 3'd2);
            chk("final_mem", ld_data, ref_mem[i]);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
